// File: rtl/round_judge.sv
// Round/score controller downstream of the card comparator: latches a card pair, scores the result, declares a winner.
// Optional build macro TIE_REPLAY_EN: ties (and illegal codes) do not consume a round.
module round_judge #(
    parameter int unsigned WIN_SCORE  = 3,
    parameter int unsigned MAX_ROUNDS = 7,
    parameter int unsigned SCORE_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_game,
    input  logic               card_valid,
    input  logic [3:0]         p1_card,
    input  logic [3:0]         p2_card,
    output logic               ready,
    output logic [3:0]         p1_handcard,
    output logic [3:0]         p2_handcard,
    input  logic [1:0]         matchresult,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [SCORE_W-1:0] round_cnt,
    output logic [1:0]         round_result,
    output logic               result_valid,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic               err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic [3:0]         p1_hand_q, p1_hand_d, p2_hand_q, p2_hand_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
    logic [SCORE_W-1:0] round_cnt_q, round_cnt_d;
    logic [1:0]         round_result_q, round_result_d;
    logic               result_valid_q, result_valid_d;
    logic               game_over_q, game_over_d;
    logic [1:0]         winner_q, winner_d;
    logic               err_q, err_d;

    logic p1_win_c, p2_win_c, tie_c, illegal_c;

    assign p1_win_c  = (matchresult == 2'b10);
    assign p2_win_c  = (matchresult == 2'b11);
    assign illegal_c = (matchresult == 2'b00);
    assign tie_c     = ~p1_win_c & ~p2_win_c;

    always_comb begin
        state_d        = state_q;
        p1_hand_d      = p1_hand_q;
        p2_hand_d      = p2_hand_q;
        p1_score_d     = p1_score_q;
        p2_score_d     = p2_score_q;
        round_cnt_d    = round_cnt_q;
        round_result_d = round_result_q;
        result_valid_d = 1'b0;
        winner_d       = winner_q;
        err_d          = err_q;

        case (state_q)
            S_IDLE: begin
                if (card_valid) begin
                    p1_hand_d = p1_card;
                    p2_hand_d = p2_card;
                    state_d   = S_COMPARE;
                end
            end
            S_COMPARE: begin
                p1_score_d     = p1_score_q + SCORE_W'(p1_win_c);
                p2_score_d     = p2_score_q + SCORE_W'(p2_win_c);
`ifdef TIE_REPLAY_EN
                round_cnt_d    = round_cnt_q + SCORE_W'(~tie_c);
`else
                round_cnt_d    = round_cnt_q + SCORE_W'(1);
`endif
                round_result_d = tie_c ? 2'b01 : matchresult;
                err_d          = err_q | illegal_c;
                result_valid_d = 1'b1;
                // End-of-game decision uses the freshly updated counters
                if ((p1_score_d == SCORE_W'(WIN_SCORE)) || (p2_score_d == SCORE_W'(WIN_SCORE)) ||
                    (round_cnt_d == SCORE_W'(MAX_ROUNDS))) begin
                    state_d = S_DONE;
                    if (p1_score_d > p2_score_d)      winner_d = 2'b01;
                    else if (p2_score_d > p1_score_d) winner_d = 2'b10;
                    else                              winner_d = 2'b11;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Restart wins over everything, dropping any offered or in-flight pair
        if (new_game) begin
            state_d        = S_IDLE;
            p1_hand_d      = p1_hand_q;
            p2_hand_d      = p2_hand_q;
            p1_score_d     = '0;
            p2_score_d     = '0;
            round_cnt_d    = '0;
            round_result_d = 2'b00;
            result_valid_d = 1'b0;
            winner_d       = 2'b00;
            err_d          = 1'b0;
        end

        ready_d     = (state_d == S_IDLE);
        game_over_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ready_q        <= 1'b1;
            p1_hand_q      <= 4'd0;
            p2_hand_q      <= 4'd0;
            p1_score_q     <= '0;
            p2_score_q     <= '0;
            round_cnt_q    <= '0;
            round_result_q <= 2'b00;
            result_valid_q <= 1'b0;
            game_over_q    <= 1'b0;
            winner_q       <= 2'b00;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            ready_q        <= ready_d;
            p1_hand_q      <= p1_hand_d;
            p2_hand_q      <= p2_hand_d;
            p1_score_q     <= p1_score_d;
            p2_score_q     <= p2_score_d;
            round_cnt_q    <= round_cnt_d;
            round_result_q <= round_result_d;
            result_valid_q <= result_valid_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
            err_q          <= err_d;
        end
    end

    assign ready        = ready_q;
    assign p1_handcard  = p1_hand_q;
    assign p2_handcard  = p2_hand_q;
    assign p1_score     = p1_score_q;
    assign p2_score     = p2_score_q;
    assign round_cnt    = round_cnt_q;
    assign round_result = round_result_q;
    assign result_valid = result_valid_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;
    assign err          = err_q;

endmodule

// File: tb/tb_round_judge.sv
// Scoreboard bench for round_judge: expected round results are queued at acceptance and checked on result_valid.
module tb_round_judge;

    localparam int unsigned SCORE_W = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               new_game = 1'b0;
    logic               card_valid = 1'b0;
    logic [3:0]         p1_card = 4'd0;
    logic [3:0]         p2_card = 4'd0;
    logic [1:0]         matchresult = 2'b01;
    logic               ready;
    logic [3:0]         p1_handcard, p2_handcard;
    logic [SCORE_W-1:0] p1_score, p2_score, round_cnt;
    logic [1:0]         round_result, winner;
    logic               result_valid, game_over, err;

    round_judge #(.WIN_SCORE(3), .MAX_ROUNDS(7), .SCORE_W(SCORE_W)) dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game), .card_valid(card_valid),
        .p1_card(p1_card), .p2_card(p2_card), .ready(ready),
        .p1_handcard(p1_handcard), .p2_handcard(p2_handcard), .matchresult(matchresult),
        .p1_score(p1_score), .p2_score(p2_score), .round_cnt(round_cnt),
        .round_result(round_result), .result_valid(result_valid), .game_over(game_over),
        .winner(winner), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p1;
        int p2;
        int rc;
        int rr;
        int er;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference game state
    int m_p1 = 0, m_p2 = 0, m_rc = 0, m_err = 0, m_win = 0;
    bit m_done = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rv_p1_score", int'(p1_score), e.p1);
                check("rv_p2_score", int'(p2_score), e.p2);
                check("rv_round_cnt", int'(round_cnt), e.rc);
                check("rv_round_result", int'(round_result), e.rr);
                check("rv_err", int'(err), e.er);
            end
        end
    end

    task automatic model_clear();
        m_p1 = 0; m_p2 = 0; m_rc = 0; m_err = 0; m_win = 0; m_done = 1'b0;
    endtask

    task automatic drive_pair(input logic [3:0] c1, input logic [3:0] c2,
                              input logic [1:0] mr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("ready_wait_timeout", 0, 1);
            return;
        end
        card_valid  = 1'b1;
        p1_card     = c1;
        p2_card     = c2;
        matchresult = mr;
        @(negedge clk);
        card_valid = 1'b0;
    endtask

    task automatic play_round(input logic [3:0] c1, input logic [3:0] c2, input logic [1:0] mr);
        bit   ok;
        bit   tie;
        exp_t e;
        drive_pair(c1, c2, mr, ok);
        if (!ok) return;
        tie = (mr == 2'b01) || (mr == 2'b00);
        if (mr == 2'b10) m_p1++;
        if (mr == 2'b11) m_p2++;
        if (mr == 2'b00) m_err = 1;
`ifdef TIE_REPLAY_EN
        if (!tie) m_rc++;
`else
        m_rc++;
`endif
        m_done = (m_p1 == 3) || (m_p2 == 3) || (m_rc == 7);
        if (m_done) m_win = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 3;
        e.p1 = m_p1; e.p2 = m_p2; e.rc = m_rc; e.rr = tie ? 1 : int'(mr); e.er = m_err;
        sb_q.push_back(e);
        check("cmp_p1_handcard", int'(p1_handcard), int'(c1));
        check("cmp_p2_handcard", int'(p2_handcard), int'(c2));
        check("cmp_ready", int'(ready), 0);
        @(negedge clk);
        check("post_ready", int'(ready), m_done ? 0 : 1);
        check("post_game_over", int'(game_over), m_done ? 1 : 0);
        check("post_winner", int'(winner), m_win);
    endtask

    task automatic do_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
        check("ng_p1_score", int'(p1_score), 0);
        check("ng_p2_score", int'(p2_score), 0);
        check("ng_round_cnt", int'(round_cnt), 0);
        check("ng_round_result", int'(round_result), 0);
        check("ng_winner", int'(winner), 0);
        check("ng_game_over", int'(game_over), 0);
        check("ng_err", int'(err), 0);
        check("ng_ready", int'(ready), 1);
    endtask

    initial begin
        bit ok;
        logic [1:0] seq7 [7] = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b01};

        // Reset values
        @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_p1_score", int'(p1_score), 0);
        check("rst_round_cnt", int'(round_cnt), 0);
        check("rst_handcard", int'(p1_handcard), 0);
        check("rst_winner", int'(winner), 0);
        check("rst_game_over", int'(game_over), 0);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of COMPARE
        drive_pair(4'd9, 4'd4, 2'b10, ok);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", int'(ready), 1);
        check("midrst_handcard", int'(p1_handcard), 0);
        check("midrst_p1_score", int'(p1_score), 0);
        check("midrst_round_cnt", int'(round_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_no_rv", int'(result_valid), 0);

        // Single P1 win
        play_round(4'd9, 4'd4, 2'b10);

        // Three P2 wins end the game; further cards ignored
        do_new_game();
        for (int i = 0; i < 3; i++) play_round(4'd2, 4'd11, 2'b11);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            card_valid = 1'b1;
            check("done_ready", int'(ready), 0);
            check("done_game_over", int'(game_over), 1);
            check("done_winner", int'(winner), 2);
        end
        card_valid = 1'b0;

        // Seven-round game ending in a draw (tie-replay keeps it running)
        do_new_game();
        for (int i = 0; i < 7; i++) play_round(4'(i + 1), 4'(7 - i), seq7[i]);

        // Illegal comparator code sets a sticky error
        do_new_game();
        play_round(4'd3, 4'd3, 2'b00);
        play_round(4'd8, 4'd1, 2'b10);
        check("err_sticky", int'(err), 1);
        do_new_game();

        // new_game together with card_valid in IDLE drops the pair
        @(negedge clk);
        new_game = 1'b1;
        card_valid = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        card_valid = 1'b0;
        check("ngcv_ready", int'(ready), 1);
        check("ngcv_round_cnt", int'(round_cnt), 0);
        @(negedge clk);
        check("ngcv_still_idle", int'(ready), 1);

        // new_game during COMPARE discards the in-flight round
        drive_pair(4'd5, 4'd2, 2'b10, ok);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check("ngcmp_ready", int'(ready), 1);
        check("ngcmp_p1_score", int'(p1_score), 0);
        check("ngcmp_round_cnt", int'(round_cnt), 0);

        repeat (4) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/round_judge.md
Name: round_judge

Overview:
- Sequential match controller placed directly downstream of the 4-bit card comparator.
- Accepts one pair of hand cards per round and presents them to the comparator.
- Consumes the comparator's 2-bit matchresult, keeps both players' scores and the round count, and declares the game winner.

Parameters:
- WIN_SCORE, 3: score at which a player wins immediately.
- MAX_ROUNDS, 7: round limit; the game ends when round_cnt reaches it.
- SCORE_W, 3: width of the score and round counters; must hold MAX_ROUNDS.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- new_game  input  1  synchronous clear and restart; highest priority after reset.
- card_valid  input  1  card pair offered this cycle.
- p1_card  input  4  player 1 card.
- p2_card  input  4  player 2 card.
- ready  output  1  block accepts card_valid this cycle.
- p1_handcard  output  4  registered player 1 card, driven to the comparator.
- p2_handcard  output  4  registered player 2 card, driven to the comparator.
- matchresult  input  2  comparator result. Encoding: 2'b10 = P1 higher, 2'b11 = P2 higher, 2'b01 = tie, 2'b00 = illegal.
- p1_score  output  SCORE_W  player 1 rounds won.
- p2_score  output  SCORE_W  player 2 rounds won.
- round_cnt  output  SCORE_W  rounds counted.
- round_result  output  2  last round outcome, same encoding as matchresult; 2'b00 after a tie is replaced (see below) is never produced.
- result_valid  output  1  one-cycle pulse when scores update.
- game_over  output  1  high in DONE.
- winner  output  2  2'b01 = P1, 2'b10 = P2, 2'b11 = draw, 2'b00 = none.
- err  output  1  sticky flag: illegal matchresult was seen.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; ready = 1.
  - All scores, round_cnt, handcards, round_result, winner = 0.
  - result_valid, game_over, err = 0.
- States: IDLE, COMPARE, DONE.
- IDLE:
  - ready = 1.
  - card_valid=1 at edge T: latch p1_card/p2_card into p1_handcard/p2_handcard; go to COMPARE.
- COMPARE (cycle T+1):
  - ready = 0. The comparator is combinational, so matchresult is sampled at the end of this cycle.
  - 10: p1_score+1. 11: p2_score+1. 01: tie, no score change. 00: treated as tie and err set.
  - round_cnt+1. round_result = sampled code, with 00 stored as 01.
  - result_valid = 1 during cycle T+2 only.
- End-of-game check, made at the same edge from the updated values:
  - If p1_score==WIN_SCORE, or p2_score==WIN_SCORE, or round_cnt==MAX_ROUNDS: go to DONE.
  - Otherwise return to IDLE; ready = 1 at T+2.
  - Round latency: one card pair per 2 cycles at most.
- DONE:
  - game_over = 1; ready = 0; card_valid ignored.
  - winner = higher score, or 2'b11 if scores are equal. winner holds until cleared.
- new_game=1 (any state, synchronous):
  - Clears scores, round_cnt, round_result, winner, game_over and err; goes to IDLE.
  - Overrides a simultaneous card_valid; the pair is dropped.
  - In COMPARE, the in-flight round is discarded with no result_valid.
- card_valid held high across rounds: a new pair is accepted every time the block is in IDLE.
- Counters never wrap, because MAX_ROUNDS ends the game first.
- rst_n asserted mid-round: immediate return to reset values.

Optional Feature:
- Macro TIE_REPLAY_EN.
- Defined: a tie (01 or illegal 00) does not increment round_cnt. result_valid still pulses and round_result=01, so ties are replayed without consuming the round limit.
- Undefined: ties consume a round as described in Behaviour.

Test Plan:
- Reset with rst_n=0 mid-COMPARE -> all outputs 0, ready=1 immediately, no result_valid.
- Cards 9 vs 4 with matchresult=10 -> at T+2 result_valid=1, p1_score=1, round_cnt=1, round_result=10, ready=1.
- Three P2 wins (matchresult=11) -> p2_score=3, game_over=1, winner=10; a further card_valid is ignored and ready=0.
- Seven rounds alternating 10,11,01,10,11,01,01 -> round_cnt=7, scores 2/2, DONE, winner=11. With TIE_REPLAY_EN defined, round_cnt=4 and the game continues.
- matchresult=00 in one round -> err=1 (sticky), no score change, round_result=01; then new_game -> err=0.
- new_game asserted together with card_valid in IDLE -> pair dropped, state IDLE, counters 0, no result_valid.
